// File: rtl/prio_encoder_arb_pkg.sv
// Shared definitions for the priority encoder / arbiter slice:
// mode encodings, FSM state type and the code-width helper.
package prio_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Ceiling log2; clog2(N+1) gives a code wide enough for 0..N
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_encoder_arb_if.sv
// Request/grant bus between request sources (master) and the arbiter (slave).
interface prio_encoder_arb_if
    import prio_pkg::*;
#(
    parameter int N = 4
) ();

    localparam int CW = clog2(N + 1);

    logic [N-1:0]  req;
    logic          mode;
    logic          ack;
    logic          out_valid;
    logic [CW-1:0] out_code;
    logic [N-1:0]  out_onehot;

    modport master (
        output req,
        output mode,
        output ack,
        input  out_valid,
        input  out_code,
        input  out_onehot
    );

    modport slave (
        input  req,
        input  mode,
        input  ack,
        output out_valid,
        output out_code,
        output out_onehot
    );

endinterface

// File: rtl/prio_encoder_arb_find.sv
// Combinational highest-set-bit finder: reports whether any bit is set,
// its 0-based index and the matching one-hot vector.
module prio_find
    import prio_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = clog2(N + 1)
) (
    input  logic [N-1:0]  vec,
    output logic          found,
    output logic [CW-1:0] idx,
    output logic [N-1:0]  onehot
);

    // Scan upward so the highest set bit is the last one recorded
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                found = 1'b1;
                idx   = CW'(i);
            end
        end
        if (found) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/prio_encoder_arb.sv
// Registered priority encoder with fixed / round-robin selection and a
// grant/ack handshake that holds each winner until it is consumed or
// its request is withdrawn.
module prio_encoder_arb
    import prio_pkg::*;
#(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    prio_encoder_arb_if.slave bus
);

    localparam int CW = clog2(N + 1);

    state_t        state;
    logic          valid_q;
    logic [CW-1:0] code_q;
    logic [N-1:0]  onehot_q;
    logic [CW-1:0] last_q;

    logic [CW-1:0] mask_base;
    logic [N-1:0]  mask;
    logic [N-1:0]  masked_req;

    logic          m_found;
    logic [CW-1:0] m_idx;
    logic [N-1:0]  m_onehot;
    logic          r_found;
    logic [CW-1:0] r_idx;
    logic [N-1:0]  r_onehot;

    logic          win_found;
    logic [CW-1:0] win_idx;
    logic [N-1:0]  win_onehot;

    // While granting, an ack makes the current winner the new "last", so the
    // round-robin mask is built from it directly to re-arbitrate in one cycle
    always_comb begin
        mask_base = (state == GRANT) ? (code_q - CW'(1)) : last_q;
        mask      = '0;
        for (int i = 0; i < N; i++) begin
            if (i < int'(mask_base)) begin
                mask[i] = 1'b1;
            end
        end
        masked_req = bus.req & mask;
    end

    prio_find #(.N(N), .CW(CW)) u_find_masked (
        .vec    (masked_req),
        .found  (m_found),
        .idx    (m_idx),
        .onehot (m_onehot)
    );

    prio_find #(.N(N), .CW(CW)) u_find_raw (
        .vec    (bus.req),
        .found  (r_found),
        .idx    (r_idx),
        .onehot (r_onehot)
    );

    // Round-robin uses the masked winner, wrapping to the raw winner when empty
    always_comb begin
        win_found  = r_found;
        win_idx    = r_idx;
        win_onehot = r_onehot;
        if ((bus.mode == MODE_RR) && m_found) begin
            win_idx    = m_idx;
            win_onehot = m_onehot;
        end
    end

    // Grant FSM with registered outputs and round-robin history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            valid_q  <= 1'b0;
            code_q   <= '0;
            onehot_q <= '0;
            last_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state    <= GRANT;
                        valid_q  <= 1'b1;
                        code_q   <= win_idx + CW'(1);
                        onehot_q <= win_onehot;
                    end else begin
                        valid_q  <= 1'b0;
                        code_q   <= '0;
                        onehot_q <= '0;
                    end
                end
                GRANT: begin
                    if (bus.ack) begin
                        last_q <= code_q - CW'(1);
                        if (win_found) begin
                            valid_q  <= 1'b1;
                            code_q   <= win_idx + CW'(1);
                            onehot_q <= win_onehot;
                        end else begin
                            state    <= IDLE;
                            valid_q  <= 1'b0;
                            code_q   <= '0;
                            onehot_q <= '0;
                        end
                    end else if ((bus.req & onehot_q) == '0) begin
                        state    <= IDLE;
                        valid_q  <= 1'b0;
                        code_q   <= '0;
                        onehot_q <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    valid_q  <= 1'b0;
                    code_q   <= '0;
                    onehot_q <= '0;
                end
            endcase
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_code   = code_q;
    assign bus.out_onehot = onehot_q;

endmodule
